// File: rtl/pong_core_param.sv
// pong_core_param: parametrised two-player paddle/ball game engine.
// Owns paddles, ball motion, collisions, scoring and game sequencing.
module pong_core_param #(
   parameter int FIELD_W    = 8,
   parameter int FIELD_H    = 16,
   parameter int BAR_LEN    = 3,
   parameter int BAR1_Y     = 12,
   parameter int BAR2_Y     = 3,
   parameter int BAR_DIV    = 2000,
   parameter int BALL_DIV   = 4000000,
   parameter int POINT_HOLD = 4,
   parameter int WIN_SCORE  = 9,
   parameter int SCORE_W    = 4,
   localparam int X_W = $clog2(FIELD_W),
   localparam int Y_W = $clog2(FIELD_H)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [3:0]         PUSH,
   input  logic               SERVE,
   output logic [X_W-1:0]     bar1_x,
   output logic [X_W-1:0]     bar2_x,
   output logic [X_W-1:0]     ball_x,
   output logic [Y_W-1:0]     ball_y,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         game_state,
   output logic               point_pulse,
   output logic               winner
);

   localparam int BC_W = $clog2(BAR_DIV + 1);
   localparam int LC_W = $clog2(BALL_DIV + 1);
   localparam int HC_W = $clog2(POINT_HOLD + 1);

   localparam logic [X_W-1:0]     BAR_MAX = X_W'(FIELD_W - BAR_LEN);
   localparam logic [X_W-1:0]     HALF    = X_W'(BAR_LEN / 2);
   localparam logic [X_W-1:0]     X_MAX   = X_W'(FIELD_W - 1);
   localparam logic [X_W:0]       LEN_W   = (X_W + 1)'(BAR_LEN);
   localparam logic [Y_W-1:0]     Y_MAX   = Y_W'(FIELD_H - 1);
   localparam logic [Y_W-1:0]     Y1_SRV  = Y_W'(BAR1_Y - 1);
   localparam logic [Y_W-1:0]     Y2_SRV  = Y_W'(BAR2_Y + 1);
   localparam logic [Y_W-1:0]     Y1_RET  = Y_W'(BAR1_Y - 2);
   localparam logic [Y_W-1:0]     Y2_RET  = Y_W'(BAR2_Y + 2);
   localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
   localparam bit                 ODD     = (BAR_LEN % 2) == 1;

   localparam logic [1:0] DX_Z = 2'b00;
   localparam logic [1:0] DX_P = 2'b01;
   localparam logic [1:0] DX_N = 2'b11;

   typedef enum logic [1:0] {
      S_SERVE = 2'd0,
      S_PLAY  = 2'd1,
      S_POINT = 2'd2,
      S_OVER  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
   logic [X_W-1:0]     bar1_q, bar1_d, bar2_q, bar2_d;
   logic [X_W-1:0]     ball_x_q, ball_x_d;
   logic [Y_W-1:0]     ball_y_q, ball_y_d;
   logic [1:0]         dx_q, dx_d;
   logic               up_q, up_d;
   logic               server_q, server_d;
   logic               pulse_q, pulse_d;
   logic               winner_q, winner_d;
   logic [BC_W-1:0]    bar_cnt_q, bar_cnt_d;
   logic [LC_W-1:0]    ball_cnt_q, ball_cnt_d;
   logic [HC_W-1:0]    hold_q, hold_d;
   logic [3:0]         push_m_q, push_s_q, push_smp_q;
   logic               serve_m_q, serve_s_q, serve_prev_q;

   logic               bar_tick, ball_tick, serve_edge;
   logic [3:0]         rise;
   logic [X_W:0]       off1, off2;
   logic               in1, in2;

   // Offsets are one bit wider so a ball left of the paddle shows as negative
   assign off1 = {1'b0, ball_x_q} - {1'b0, bar1_q};
   assign off2 = {1'b0, ball_x_q} - {1'b0, bar2_q};
   assign in1  = !off1[X_W] && (off1 < LEN_W);
   assign in2  = !off2[X_W] && (off2 < LEN_W);

   assign bar_tick   = bar_cnt_q == BC_W'(BAR_DIV - 1);
   assign ball_tick  = (state_q == S_PLAY || state_q == S_POINT) &&
                       (ball_cnt_q == LC_W'(BALL_DIV - 1));
   assign serve_edge = serve_s_q & ~serve_prev_q;
   assign rise       = push_s_q & ~push_smp_q;

   function automatic logic [1:0] hit_dx(input logic [X_W:0] off);
      if (off < {1'b0, HALF}) return DX_N;
      if (ODD && off == {1'b0, HALF}) return DX_Z;
      return DX_P;
   endfunction

   always_comb begin
      state_d    = state_q;
      score1_d   = score1_q;
      score2_d   = score2_q;
      bar1_d     = bar1_q;
      bar2_d     = bar2_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      dx_d       = dx_q;
      up_d       = up_q;
      server_d   = server_q;
      pulse_d    = 1'b0;
      winner_d   = winner_q;
      hold_d     = hold_q;
      bar_cnt_d  = bar_tick ? '0 : bar_cnt_q + BC_W'(1);
      ball_cnt_d = ball_cnt_q;

      if (state_q == S_PLAY || state_q == S_POINT)
         ball_cnt_d = ball_tick ? '0 : ball_cnt_q + LC_W'(1);

      // Left press wins over a simultaneous right press
      if (bar_tick && state_q != S_OVER) begin
         if (rise[1])
            bar1_d = (bar1_q == '0) ? bar1_q : bar1_q - X_W'(1);
         else if (rise[0])
            bar1_d = (bar1_q == BAR_MAX) ? bar1_q : bar1_q + X_W'(1);
         if (rise[3])
            bar2_d = (bar2_q == '0) ? bar2_q : bar2_q - X_W'(1);
         else if (rise[2])
            bar2_d = (bar2_q == BAR_MAX) ? bar2_q : bar2_q + X_W'(1);
      end

      unique case (state_q)
         S_SERVE: begin
            ball_x_d = (server_q ? bar2_q : bar1_q) + HALF;
            ball_y_d = server_q ? Y2_SRV : Y1_SRV;
            if (serve_edge) begin
               state_d    = S_PLAY;
               dx_d       = DX_Z;
               up_d       = !server_q;
               ball_cnt_d = '0;
            end
         end
         S_PLAY: begin
            if (ball_tick) begin
               if (up_q && ball_y_q == Y2_SRV && in2) begin
                  up_d     = 1'b0;
                  ball_y_d = Y2_RET;
                  dx_d     = hit_dx(off2);
               end else if (!up_q && ball_y_q == Y1_SRV && in1) begin
                  up_d     = 1'b1;
                  ball_y_d = Y1_RET;
                  dx_d     = hit_dx(off1);
               end else if (up_q && ball_y_q == '0) begin
                  score1_d = (score1_q == WIN) ? score1_q : score1_q + SCORE_W'(1);
                  pulse_d  = 1'b1;
                  server_d = 1'b1;
                  hold_d   = '0;
                  state_d  = S_POINT;
               end else if (!up_q && ball_y_q == Y_MAX) begin
                  score2_d = (score2_q == WIN) ? score2_q : score2_q + SCORE_W'(1);
                  pulse_d  = 1'b1;
                  server_d = 1'b0;
                  hold_d   = '0;
                  state_d  = S_POINT;
               end else begin
                  ball_y_d = up_q ? ball_y_q - Y_W'(1) : ball_y_q + Y_W'(1);
                  if (dx_q == DX_P) begin
                     if (ball_x_q == X_MAX) begin
                        ball_x_d = X_MAX - X_W'(1);
                        dx_d     = DX_N;
                     end else begin
                        ball_x_d = ball_x_q + X_W'(1);
                     end
                  end else if (dx_q == DX_N) begin
                     if (ball_x_q == '0) begin
                        ball_x_d = X_W'(1);
                        dx_d     = DX_P;
                     end else begin
                        ball_x_d = ball_x_q - X_W'(1);
                     end
                  end
               end
            end
         end
         S_POINT: begin
            if (ball_tick) begin
               if (hold_q == HC_W'(POINT_HOLD - 1)) begin
                  hold_d = '0;
                  if (score1_q == WIN || score2_q == WIN) begin
                     state_d  = S_OVER;
                     winner_d = (score2_q == WIN);
                  end else begin
                     state_d = S_SERVE;
                  end
               end else begin
                  hold_d = hold_q + HC_W'(1);
               end
            end
         end
         S_OVER: begin
            if (serve_edge) begin
               score1_d = '0;
               score2_d = '0;
               server_d = 1'b0;
               state_d  = S_SERVE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_SERVE;
         score1_q     <= '0;
         score2_q     <= '0;
         bar1_q       <= '0;
         bar2_q       <= BAR_MAX;
         ball_x_q     <= HALF;
         ball_y_q     <= Y1_SRV;
         dx_q         <= DX_Z;
         up_q         <= 1'b1;
         server_q     <= 1'b0;
         pulse_q      <= 1'b0;
         winner_q     <= 1'b0;
         bar_cnt_q    <= '0;
         ball_cnt_q   <= '0;
         hold_q       <= '0;
         push_m_q     <= '0;
         push_s_q     <= '0;
         push_smp_q   <= '0;
         serve_m_q    <= 1'b0;
         serve_s_q    <= 1'b0;
         serve_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         bar1_q       <= bar1_d;
         bar2_q       <= bar2_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         dx_q         <= dx_d;
         up_q         <= up_d;
         server_q     <= server_d;
         pulse_q      <= pulse_d;
         winner_q     <= winner_d;
         bar_cnt_q    <= bar_cnt_d;
         ball_cnt_q   <= ball_cnt_d;
         hold_q       <= hold_d;
         push_m_q     <= PUSH;
         push_s_q     <= push_m_q;
         push_smp_q   <= bar_tick ? push_s_q : push_smp_q;
         serve_m_q    <= SERVE;
         serve_s_q    <= serve_m_q;
         serve_prev_q <= serve_s_q;
      end
   end

   assign bar1_x      = bar1_q;
   assign bar2_x      = bar2_q;
   assign ball_x      = ball_x_q;
   assign ball_y      = ball_y_q;
   assign score1      = score1_q;
   assign score2      = score2_q;
   assign game_state  = state_q;
   assign point_pulse = pulse_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_pong_core_param.sv
// tb_pong_core_param: scoreboard bench for pong_core_param.
// Directed rallies with hand-traced ball paths and point expectations.
module tb_pong_core_param;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] PUSH = 4'b0;
   logic       SERVE = 1'b0;
   logic [2:0] bar1_x, bar2_x, ball_x;
   logic [3:0] ball_y;
   logic [3:0] score1, score2;
   logic [1:0] game_state;
   logic       point_pulse, winner;

   pong_core_param #(
      .BAR_DIV(2), .BALL_DIV(4), .POINT_HOLD(2), .WIN_SCORE(3)
   ) dut (
      .CLK(CLK), .RST(RST), .PUSH(PUSH), .SERVE(SERVE),
      .bar1_x(bar1_x), .bar2_x(bar2_x), .ball_x(ball_x), .ball_y(ball_y),
      .score1(score1), .score2(score2), .game_state(game_state),
      .point_pulse(point_pulse), .winner(winner)
   );

   always #5 CLK = ~CLK;

   typedef enum int {F_ST, F_S1, F_S2, F_B1, F_B2, F_BX, F_BY, F_PP, F_WIN} fld_e;
   typedef struct { string tag; fld_e f; int v; } exp_t;
   typedef struct { int s1; int s2; } pt_t;

   exp_t q[$];
   pt_t  pq[$];
   int   checks = 0;
   int   errors = 0;
   logic pulse_prev = 1'b0;
   event hit1_ev, hit2_ev;

   function automatic int fld(fld_e f);
      case (f)
         F_ST:    return int'(game_state);
         F_S1:    return int'(score1);
         F_S2:    return int'(score2);
         F_B1:    return int'(bar1_x);
         F_B2:    return int'(bar2_x);
         F_BX:    return int'(ball_x);
         F_BY:    return int'(ball_y);
         F_PP:    return int'(point_pulse);
         default: return int'(winner);
      endcase
   endfunction

   always @(negedge CLK) begin : mon
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (fld(e.f) != e.v) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", e.tag, fld(e.f), e.v);
         end
      end
   end

   always @(negedge CLK) begin : pmon
      pt_t p;
      if (point_pulse) begin
         checks++;
         if (pq.size() == 0) begin
            errors++;
            $display("FAIL point_unexpected: got s1=%0d s2=%0d want none", score1, score2);
         end else begin
            p = pq.pop_front();
            if (int'(score1) != p.s1 || int'(score2) != p.s2) begin
               errors++;
               $display("FAIL point_score: got %0d/%0d want %0d/%0d",
                        score1, score2, p.s1, p.s2);
            end
         end
         checks++;
         if (pulse_prev) begin
            errors++;
            $display("FAIL pulse_width: got 2+ cycles want 1");
         end
      end
      pulse_prev <= point_pulse;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic expect_f(string tag, fld_e f, int v);
      exp_t e;
      e.tag = tag;
      e.f   = f;
      e.v   = v;
      q.push_back(e);
   endtask

   task automatic expect_pt(int s1, int s2);
      pt_t p;
      p.s1 = s1;
      p.s2 = s2;
      pq.push_back(p);
   endtask

   task automatic wait_f(string tag, fld_e f, int v, int budget);
      int n = 0;
      while (fld(f) != v && n < budget) begin
         tick(1);
         n++;
      end
      if (fld(f) != v) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got %0d want %0d", tag, fld(f), v);
      end
   endtask

   task automatic step(int y, int x, string tag);
      wait_f({tag, "_y"}, F_BY, y, 40);
      expect_f(tag, F_BX, x);
   endtask

   task automatic press(int idx);
      PUSH[idx] = 1'b1;
      tick(6);
      PUSH[idx] = 1'b0;
      tick(6);
   endtask

   task automatic serve_btn();
      SERVE = 1'b1;
      tick(4);
      SERVE = 1'b0;
      tick(2);
   endtask

   initial begin
      int n;
      RST = 1'b1;
      tick(3);
      expect_f("rst_state", F_ST, 0);
      expect_f("rst_s1", F_S1, 0);
      expect_f("rst_s2", F_S2, 0);
      expect_f("rst_b1", F_B1, 0);
      expect_f("rst_b2", F_B2, 5);
      expect_f("rst_bx", F_BX, 1);
      expect_f("rst_by", F_BY, 11);
      expect_f("rst_pulse", F_PP, 0);
      expect_f("rst_win", F_WIN, 0);
      RST = 1'b0;
      tick(2);

      for (int i = 0; i < 6; i++) begin
         press(0);
         expect_f("b1_right", F_B1, (i + 1 > 5) ? 5 : i + 1);
      end
      expect_f("track_x", F_BX, 6);
      expect_f("track_y", F_BY, 11);
      expect_f("track_st", F_ST, 0);
      PUSH[1:0] = 2'b11;
      tick(6);
      PUSH[1:0] = 2'b00;
      tick(6);
      expect_f("both_left", F_B1, 4);
      repeat (5) press(1);
      expect_f("b1_clamp0", F_B1, 0);
      expect_f("track_x0", F_BX, 1);

      serve_btn();
      expect_f("serve_play", F_ST, 1);
      step(4, 1, "rise_c1");
      expect_pt(1, 0);
      wait_f("pt1", F_ST, 2, 80);
      expect_f("pt1_s1", F_S1, 1);
      expect_f("pt1_by", F_BY, 0);
      expect_f("pt1_bx", F_BX, 1);
      n = 0;
      while (game_state == 2'd2 && n < 50) begin
         tick(1);
         n++;
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL point_len: got %0d want 8", n);
      end
      expect_f("pt1_serve", F_ST, 0);
      tick(1);
      expect_f("p2_srv_x", F_BX, 6);
      expect_f("p2_srv_y", F_BY, 4);

      repeat (5) press(3);
      expect_f("b2_left", F_B2, 0);
      expect_f("p2_trk_x", F_BX, 1);
      serve_btn();
      expect_f("serve2_play", F_ST, 1);
      fork
         begin
            press(2);
            @(hit1_ev);
            repeat (3) press(0);
            @(hit2_ev);
            press(1);
         end
         begin
            step(11, 1, "down_c1");
            step(10, 1, "hit1_off1");
            ->hit1_ev;
            step(9, 1, "dx_zero");
            step(4, 1, "up_c1");
            step(5, 1, "hit2_off0");
            step(6, 0, "dx_neg");
            step(7, 1, "refl_x0");
            step(8, 2, "dx_pos");
            step(11, 5, "to_b1");
            step(10, 5, "hit1_off2");
            ->hit2_ev;
            step(9, 6, "dx_pos2");
            step(8, 7, "at_x7");
            step(7, 6, "refl_x7");
            step(4, 3, "to_b2");
            step(5, 3, "hit2_off2");
            step(6, 4, "dx_pos3");
            step(10, 6, "refl_x7b");
            step(11, 5, "miss_b1");
            expect_pt(1, 1);
            step(12, 4, "past_b1");
            step(15, 1, "bottom");
         end
      join
      wait_f("pt2", F_ST, 2, 20);
      expect_f("pt2_s2", F_S2, 1);
      wait_f("pt2_srv", F_ST, 0, 20);
      tick(1);
      expect_f("p1_srv_x", F_BX, 3);
      expect_f("p1_srv_y", F_BY, 11);
      expect_f("b1_final", F_B1, 2);
      expect_f("b2_final", F_B2, 1);

      repeat (3) press(2);
      expect_f("b2_right", F_B2, 4);
      serve_btn();
      expect_pt(2, 1);
      wait_f("pt3", F_ST, 2, 100);
      wait_f("pt3_srv", F_ST, 0, 20);
      tick(1);
      expect_f("p2_srv_x2", F_BX, 5);
      press(0);
      expect_f("b1_to3", F_B1, 3);
      serve_btn();
      expect_pt(3, 1);
      step(11, 5, "d_c5");
      step(10, 5, "hit_b1_c5");
      step(7, 6, "refl_x7c");
      step(3, 2, "past_b2");
      wait_f("pt4", F_ST, 2, 60);
      expect_f("pt4_bx", F_BX, 1);
      expect_f("pt4_by", F_BY, 0);
      wait_f("over", F_ST, 3, 20);
      expect_f("over_win", F_WIN, 0);
      expect_f("over_s1", F_S1, 3);
      expect_f("over_s2", F_S2, 1);
      press(0);
      press(3);
      expect_f("over_b1", F_B1, 3);
      expect_f("over_b2", F_B2, 4);
      expect_f("over_bx", F_BX, 1);
      expect_f("over_by", F_BY, 0);
      serve_btn();
      expect_f("restart_st", F_ST, 0);
      expect_f("restart_s1", F_S1, 0);
      expect_f("restart_s2", F_S2, 0);
      expect_f("restart_b1", F_B1, 3);
      expect_f("restart_bx", F_BX, 4);
      expect_f("restart_by", F_BY, 11);

      serve_btn();
      expect_f("play3", F_ST, 1);
      serve_btn();
      expect_f("serve_ignored", F_ST, 1);
      RST = 1'b1;
      tick(1);
      expect_f("mid_rst_st", F_ST, 0);
      expect_f("mid_rst_s1", F_S1, 0);
      expect_f("mid_rst_b1", F_B1, 0);
      expect_f("mid_rst_b2", F_B2, 5);
      expect_f("mid_rst_bx", F_BX, 1);
      expect_f("mid_rst_by", F_BY, 11);
      expect_f("mid_rst_pp", F_PP, 0);
      expect_f("mid_rst_win", F_WIN, 0);
      RST = 1'b0;
      tick(3);

      checks++;
      if (pq.size() != 0) begin
         errors++;
         $display("FAIL points_pending: got %0d want 0", pq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
